// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event generator: per-button FSM state
// encoding, channel count and the bit offsets of each event group inside the
// 20-bit event / clear vector.
package btn_event_pkg;

   localparam int NUM_BTN = 4;

   // Event vector layout: [3:0] down, [7:4] up, [11:8] shrt, [15:12] long, [19:16] imm
   localparam int EVT_DOWN_OFS = 0;
   localparam int EVT_UP_OFS   = 4;
   localparam int EVT_SHRT_OFS = 8;
   localparam int EVT_LONG_OFS = 12;
   localparam int EVT_IMM_OFS  = 16;
   localparam int EVT_W        = 20;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRESS_DB  = 3'd1,
      ST_HELD      = 3'd2,
      ST_LONG_HELD = 3'd3,
      ST_REL_DB    = 3'd4
   } btn_state_t;

   // Largest of the three timing parameters; sets the shared counter width.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/btn_event_chan.sv
// One button channel: synchronizer, debounce / hold FSM, counters and the
// sticky event flags with rising-edge software clear.
// Optional feature: define BTN_EVENT_AUTOREPEAT_EN to re-set the long flag
// every REPEAT_CYC cycles while the button stays held past LONG_CYC.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | button released and debounced
// ST_PRESS_DB  | press seen, counting stable pressed cycles
// ST_HELD      | debounced press, counting toward the long threshold
// ST_LONG_HELD | long threshold reached, optional auto-repeat running
// ST_REL_DB    | release seen, counting stable released cycles
module btn_event_chan
   import btn_event_pkg::*;
#(
   parameter int DEBOUNCE_CYC   = 1000000,
   parameter int LONG_CYC       = 100000000,
   parameter int REPEAT_CYC     = 20000000,
   parameter int BTN_ACTIVE_LOW = 1
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic       pin,
   input  logic [3:0] clr,       // {long, shrt, up, down}
   output logic       down,
   output logic       up,
   output logic       shrt,
   output logic       long_evt,
   output logic       imm
);

   localparam int CW = $clog2(max3(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)) + 1;
   localparam logic [CW-1:0] DB_TC   = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYC - 1);
`ifdef BTN_EVENT_AUTOREPEAT_EN
   localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_CYC - 1);
`endif

   // The inversion is a constant wire, so the synchronizer carries the
   // "pressed" sense and its reset value of 0 reads as released.
   logic          pin_pressed;
   logic [1:0]    sync_q;
   logic          pressed;
   logic [3:0]    clr_q;
   logic [3:0]    clr_rise;

   btn_state_t    state;
   logic [CW-1:0] cnt_db;
   logic [CW-1:0] cnt_hold;
   logic          long_done;
`ifdef BTN_EVENT_AUTOREPEAT_EN
   logic [CW-1:0] cnt_rep;
`endif

   assign pin_pressed = (BTN_ACTIVE_LOW != 0) ? ~pin : pin;
   assign pressed     = sync_q[1];
   assign clr_rise    = clr & ~clr_q;

   // Two-flop synchronizer for the asynchronous pin.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], pin_pressed};
      end
   end

   // Previous clear levels, for rising-edge detection.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         clr_q <= '0;
      end else begin
         clr_q <= clr;
      end
   end

   // Button FSM with counters and sticky flags; the FSM sets are written
   // after the clears so a set on the same edge wins.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= ST_IDLE;
         cnt_db    <= '0;
         cnt_hold  <= '0;
         long_done <= 1'b0;
         down      <= 1'b0;
         up        <= 1'b0;
         shrt      <= 1'b0;
         long_evt  <= 1'b0;
         imm       <= 1'b0;
`ifdef BTN_EVENT_AUTOREPEAT_EN
         cnt_rep   <= '0;
`endif
      end else begin
         if (clr_rise[0]) down     <= 1'b0;
         if (clr_rise[1]) up       <= 1'b0;
         if (clr_rise[2]) shrt     <= 1'b0;
         if (clr_rise[3]) long_evt <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (pressed) begin
                  state  <= ST_PRESS_DB;
                  cnt_db <= '0;
               end
            end

            ST_PRESS_DB: begin
               if (!pressed) begin
                  state <= ST_IDLE;
               end else if (cnt_db == DB_TC) begin
                  state     <= ST_HELD;
                  down      <= 1'b1;
                  imm       <= 1'b1;
                  cnt_hold  <= '0;
                  long_done <= 1'b0;
               end else if (cnt_db != '1) begin
                  cnt_db <= cnt_db + 1'b1;
               end
            end

            ST_HELD: begin
               if (!pressed) begin
                  state  <= ST_REL_DB;
                  cnt_db <= '0;
               end else if (cnt_hold == LONG_TC) begin
                  state     <= ST_LONG_HELD;
                  long_evt  <= 1'b1;
                  long_done <= 1'b1;
`ifdef BTN_EVENT_AUTOREPEAT_EN
                  cnt_rep   <= '0;
`endif
               end else if (cnt_hold != '1) begin
                  cnt_hold <= cnt_hold + 1'b1;
               end
            end

            ST_LONG_HELD: begin
               if (!pressed) begin
                  state  <= ST_REL_DB;
                  cnt_db <= '0;
               end
`ifdef BTN_EVENT_AUTOREPEAT_EN
               else if (cnt_rep == REP_TC) begin
                  long_evt <= 1'b1;
                  cnt_rep  <= '0;
               end else if (cnt_rep != '1) begin
                  cnt_rep <= cnt_rep + 1'b1;
               end
`endif
            end

            ST_REL_DB: begin
               if (pressed) begin
                  // Bounce during release: resume where the hold left off.
                  state <= long_done ? ST_LONG_HELD : ST_HELD;
               end else if (cnt_db == DB_TC) begin
                  state <= ST_IDLE;
                  up    <= 1'b1;
                  imm   <= 1'b0;
                  if (!long_done) shrt <= 1'b1;
               end else if (cnt_db != '1) begin
                  cnt_db <= cnt_db + 1'b1;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/btn_event_gen.sv
// Four-button event generator: one independent btn_event_chan per pin, with
// the sticky flags and live level gathered into per-event output vectors.
// Optional feature: define BTN_EVENT_AUTOREPEAT_EN for long-press auto-repeat.
module btn_event_gen
   import btn_event_pkg::*;
#(
   parameter int DEBOUNCE_CYC   = 1000000,
   parameter int LONG_CYC       = 100000000,
   parameter int REPEAT_CYC     = 20000000,
   parameter int BTN_ACTIVE_LOW = 1
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic [NUM_BTN-1:0] btn_pin,
   input  logic [EVT_W-1:0]   evt_clr,
   output logic [NUM_BTN-1:0] btn_down,
   output logic [NUM_BTN-1:0] btn_up,
   output logic [NUM_BTN-1:0] btn_shrt,
   output logic [NUM_BTN-1:0] btn_long,
   output logic [NUM_BTN-1:0] btn_imm
);

   // imm is a live level, so its clear bits have no effect.
   logic unused_clr_imm;
   assign unused_clr_imm = ^evt_clr[EVT_IMM_OFS +: NUM_BTN];

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      btn_event_chan #(
         .DEBOUNCE_CYC   (DEBOUNCE_CYC),
         .LONG_CYC       (LONG_CYC),
         .REPEAT_CYC     (REPEAT_CYC),
         .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
      ) u_chan (
         .aclk     (aclk),
         .aresetn  (aresetn),
         .pin      (btn_pin[i]),
         .clr      ({evt_clr[EVT_LONG_OFS + i], evt_clr[EVT_SHRT_OFS + i],
                     evt_clr[EVT_UP_OFS + i],   evt_clr[EVT_DOWN_OFS + i]}),
         .down     (btn_down[i]),
         .up       (btn_up[i]),
         .shrt     (btn_shrt[i]),
         .long_evt (btn_long[i]),
         .imm      (btn_imm[i])
      );
   end

endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench for btn_event_gen (DEBOUNCE_CYC=8, LONG_CYC=64, REPEAT_CYC=16).
// Stimulus pushes the expected output vector and the edge at which it must
// appear; the monitor pops an entry whenever the DUT output vector changes.
module tb_btn_event_gen;

   localparam int DEB = 8;
   localparam int LNG = 64;
   localparam int REP = 16;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b1;
   logic [3:0]  btn_pin = 4'hF;
   logic [19:0] evt_clr = '0;
   logic [3:0]  btn_down, btn_up, btn_shrt, btn_long, btn_imm;
   logic [19:0] out_vec;

   btn_event_gen #(
      .DEBOUNCE_CYC   (DEB),
      .LONG_CYC       (LNG),
      .REPEAT_CYC     (REP),
      .BTN_ACTIVE_LOW (1)
   ) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .btn_pin  (btn_pin),
      .evt_clr  (evt_clr),
      .btn_down (btn_down),
      .btn_up   (btn_up),
      .btn_shrt (btn_shrt),
      .btn_long (btn_long),
      .btn_imm  (btn_imm)
   );

   assign out_vec = {btn_imm, btn_long, btn_shrt, btn_up, btn_down};

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   typedef struct {
      int          at;
      logic [19:0] vec;
      string       name;
   } exp_t;

   exp_t        exp_q[$];
   logic [19:0] model = '0;
   logic [19:0] prev_vec = '0;
   int          checks = 0;
   int          failures = 0;
   int          t, r;

   // Monitor: every change of the output vector must match the next entry.
   always @(negedge aclk) begin
      if (out_vec !== prev_vec) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change cyc=%0d got=%h (no event expected)", cyc, out_vec);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (out_vec !== e.vec || cyc != e.at) begin
               failures++;
               $display("FAIL %s: got vec=%h at cyc=%0d, expected vec=%h at cyc=%0d",
                        e.name, out_vec, cyc, e.vec, e.at);
            end
         end
         prev_vec = out_vec;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic push_exp(input int at, input logic [19:0] v, input string nm);
      exp_q.push_back('{at, v, nm});
      model = v;
   endtask

   task automatic check_now(input string nm);
      checks++;
      if (out_vec !== model) begin
         failures++;
         $display("FAIL %s: got vec=%h expected vec=%h", nm, out_vec, model);
      end
   endtask

   // Only used at quiet points where no button is pressed (imm all zero).
   task automatic clear_all(input string nm);
      evt_clr = '0;
      step(1);
      if (model != 20'h0) push_exp(cyc + 1, 20'h0, nm);
      evt_clr = 20'hFFFFF;
      step(1);
      evt_clr = '0;
      step(1);
      check_now({nm, "_after"});
   endtask

   initial begin
      #2 aresetn = 1'b0;
      step(1);
      check_now("reset_state");
      step(2);
      aresetn = 1'b1;
      step(3);
      check_now("idle_after_reset");

      // btn0 short press
      t = cyc;
      btn_pin[0] = 1'b0;
      push_exp(t + DEB + 3, 20'h10001, "b0_down");
      wait_until(t + 31);
      r = cyc;
      btn_pin[0] = 1'b1;
      push_exp(r + DEB + 3, 20'h00111, "b0_up_shrt");
      wait_until(r + DEB + 5);
      check_now("b0_short_done");
      clear_all("clear_a");

      // btn1 long press
      t = cyc;
      btn_pin[1] = 1'b0;
      push_exp(t + DEB + 3, 20'h20002, "b1_down");
      push_exp(t + DEB + 3 + LNG, 20'h22002, "b1_long");
`ifdef BTN_EVENT_AUTOREPEAT_EN
      wait_until(t + 80);
      evt_clr = 20'h02000;
      push_exp(t + 81, 20'h20002, "b1_long_cleared");
      push_exp(t + DEB + 3 + LNG + REP, 20'h22002, "b1_long_repeat");
      step(1);
      evt_clr = '0;
`endif
      wait_until(t + 100);
      r = cyc;
      btn_pin[1] = 1'b1;
      push_exp(r + DEB + 3, 20'h02022, "b1_up_no_shrt");
      wait_until(r + DEB + 5);
      check_now("b1_long_done");
      clear_all("clear_b");

      // btn2 glitch, then a real press proving the FSM restarted from idle
      t = cyc;
      btn_pin[2] = 1'b0;
      wait_until(t + 5);
      btn_pin[2] = 1'b1;
      wait_until(t + 25);
      check_now("b2_glitch_no_event");
      t = cyc;
      btn_pin[2] = 1'b0;
      push_exp(t + DEB + 3, 20'h40004, "b2_down_after_glitch");
      wait_until(t + 20);
      r = cyc;
      btn_pin[2] = 1'b1;
      push_exp(r + DEB + 3, 20'h00444, "b2_up_shrt");
      wait_until(r + DEB + 5);
      clear_all("clear_c");

      // set vs clear on the same edge, then held-high clear
      t = cyc;
      btn_pin[0] = 1'b0;
      push_exp(t + DEB + 3, 20'h10001, "b0_set_wins");
      wait_until(t + DEB + 2);
      evt_clr[0] = 1'b1;
      wait_until(t + 20);
      r = cyc;
      btn_pin[0] = 1'b1;
      push_exp(r + DEB + 3, 20'h00111, "b0_up_with_clr_high");
      wait_until(r + DEB + 5);
      evt_clr[0] = 1'b0;
      step(1);
      evt_clr[0] = 1'b1;
      push_exp(cyc + 1, 20'h00110, "b0_down_cleared");
      step(2);
      t = cyc;
      btn_pin[0] = 1'b0;
      push_exp(t + DEB + 3, 20'h10111, "b0_down_clr_held");
      wait_until(t + 20);
      r = cyc;
      btn_pin[0] = 1'b1;
      push_exp(r + DEB + 3, 20'h00111, "b0_imm_off");
      wait_until(r + DEB + 5);
      clear_all("clear_d");

      // reset while btn3 is in long hold
      t = cyc;
      btn_pin[3] = 1'b0;
      push_exp(t + DEB + 3, 20'h80008, "b3_down");
      push_exp(t + DEB + 3 + LNG, 20'h88008, "b3_long");
      wait_until(t + 80);
      aresetn = 1'b0;
      push_exp(cyc, 20'h00000, "b3_reset_clears");
      step(1);
      check_now("b3_in_reset");
      step(2);
      r = cyc;
      aresetn = 1'b1;
      push_exp(r + DEB + 3, 20'h80008, "b3_fresh_down");
      wait_until(r + 20);
      t = cyc;
      btn_pin[3] = 1'b1;
      push_exp(t + DEB + 3, 20'h00888, "b3_up_shrt");
      wait_until(t + DEB + 5);
      clear_all("clear_e");

      // all four buttons together
      t = cyc;
      btn_pin = 4'h0;
      push_exp(t + DEB + 3, 20'hF000F, "all_down");
      wait_until(t + 20);
      r = cyc;
      btn_pin = 4'hF;
      push_exp(r + DEB + 3, 20'h00FFF, "all_up_shrt");
      wait_until(r + DEB + 5);
      check_now("all_done");
      clear_all("clear_f");

      step(5);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_events: got %0d entries left, expected 0 (next %s)",
                  exp_q.size(), exp_q[0].name);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      repeat (5000) @(posedge aclk);
      failures++;
      $display("FAIL watchdog: got no completion after 5000 cycles, expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
